// File: rtl/dn_ram_arbiter.sv
// dn_ram_arbiter: merges the CMD loader stream and the raw cassette (ioctl index 1)
// stream into the single TRS-80 RAM download port, one write per granted RAM slot.
module dn_ram_arbiter #(
    parameter int DEPTH       = 4,
    parameter int WAIT_THRESH = 2,
    parameter int MIN_GAP     = 4,
    parameter int TAIL        = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        loader_download,
    input  logic        loader_wr,
    input  logic [15:0] loader_addr,
    input  logic [7:0]  loader_data,
    output logic        loader_wait,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    input  logic        ram_slot,
    output logic        dn_go,
    output logic        dn_wr,
    output logic [23:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TAIL + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_TAIL} state_t;

    // Entries hold {addr16, data8}; the high address byte is implied by the source.
    logic [23:0]   l_mem [DEPTH];
    logic [23:0]   c_mem [DEPTH];
    logic [AW-1:0] l_rd, l_wr, c_rd, c_wr;
    logic [CW-1:0] l_cnt, c_cnt, l_cnt_nxt, c_cnt_nxt;

    state_t        state;
    logic [3:0]    gap_cnt;
    logic [TW-1:0] tail_cnt;
    logic          last_cass;

    logic l_push, c_push, l_full, c_full, l_empty, c_empty;
    logic l_do_push, c_do_push, l_pop, c_pop, pop_ok, pick_cass, sess;

    assign l_push    = loader_wr;
    assign c_push    = ioctl_wr && (ioctl_index == 8'd1);
    assign l_full    = (l_cnt == CW'(DEPTH));
    assign c_full    = (c_cnt == CW'(DEPTH));
    assign l_empty   = (l_cnt == '0);
    assign c_empty   = (c_cnt == '0);
    assign l_do_push = l_push && !l_full;
    assign c_do_push = c_push && !c_full;
    assign sess      = loader_download || (ioctl_download && (ioctl_index == 8'd1));

    // Round-robin: with both sources ready, the previous winner yields.
    assign pop_ok    = (state == S_ISSUE) && ram_slot && !(l_empty && c_empty);
    assign pick_cass = c_empty ? 1'b0 : (l_empty ? 1'b1 : !last_cass);
    assign l_pop     = pop_ok && !pick_cass;
    assign c_pop     = pop_ok && pick_cass;

    always_comb begin
        l_cnt_nxt = l_cnt;
        c_cnt_nxt = c_cnt;
        if (l_do_push) l_cnt_nxt = l_cnt_nxt + CW'(1);
        if (l_pop)     l_cnt_nxt = l_cnt_nxt - CW'(1);
        if (c_do_push) c_cnt_nxt = c_cnt_nxt + CW'(1);
        if (c_pop)     c_cnt_nxt = c_cnt_nxt - CW'(1);
    end

    always_ff @(posedge clk_sys) begin
        if (l_do_push) l_mem[l_wr] <= {loader_addr, loader_data};
        if (c_do_push) c_mem[c_wr] <= {ioctl_addr, ioctl_data};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            l_rd        <= '0;
            l_wr        <= '0;
            c_rd        <= '0;
            c_wr        <= '0;
            l_cnt       <= '0;
            c_cnt       <= '0;
            loader_wait <= 1'b0;
            ioctl_wait  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (l_do_push) l_wr <= l_wr + AW'(1);
            if (c_do_push) c_wr <= c_wr + AW'(1);
            if (l_pop)     l_rd <= l_rd + AW'(1);
            if (c_pop)     c_rd <= c_rd + AW'(1);
            l_cnt       <= l_cnt_nxt;
            c_cnt       <= c_cnt_nxt;
            loader_wait <= (l_cnt_nxt >= CW'(WAIT_THRESH));
            ioctl_wait  <= (c_cnt_nxt >= CW'(WAIT_THRESH));
            if ((l_push && l_full) || (c_push && c_full)) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            tail_cnt  <= '0;
            last_cass <= 1'b1;
            dn_go     <= 1'b0;
            dn_wr     <= 1'b0;
            dn_addr   <= '0;
            dn_data   <= '0;
        end else begin
            dn_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!l_empty || !c_empty || sess) begin
                        state <= S_ISSUE;
                        dn_go <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (pop_ok) begin
                        dn_wr     <= 1'b1;
                        last_cass <= pick_cass;
                        if (pick_cass) begin
                            dn_addr <= {8'h01, c_mem[c_rd][23:8]};
                            dn_data <= c_mem[c_rd][7:0];
                        end else begin
                            dn_addr <= {8'h00, l_mem[l_rd][23:8]};
                            dn_data <= l_mem[l_rd][7:0];
                        end
                        gap_cnt <= 4'(MIN_GAP - 1);
                        state   <= (MIN_GAP > 1) ? S_GAP : S_ISSUE;
                    end else if (l_empty && c_empty && !sess) begin
                        state    <= S_TAIL;
                        tail_cnt <= TW'(TAIL - 1);
                    end
                end
                // The pulse cycle plus MIN_GAP-1 GAP cycles spaces writes MIN_GAP apart.
                S_GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt == 4'd1) state <= S_ISSUE;
                end
                S_TAIL: begin
                    if (l_push || c_push || !l_empty || !c_empty || sess) begin
                        state <= S_ISSUE;
                    end else if (tail_cnt == '0) begin
                        state <= S_IDLE;
                        dn_go <= 1'b0;
                    end else begin
                        tail_cnt <= tail_cnt - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/dn_ram_arbiter.md
Name: dn_ram_arbiter

Overview:
- Sequences the two download write streams into the single TRS-80 RAM download port (dn_go/dn_wr/dn_addr/dn_data).
- Stream 1: CMD loader output. Stream 2: raw ioctl cassette writes (index 1).
- Each stream is buffered in its own small FIFO and issued only in RAM write slots granted by the core.
- Each source is back-pressured through a wait signal; no write is lost while waits are obeyed.

Parameters:
- DEPTH, 4: entries per source FIFO (power of two, 2..16).
- WAIT_THRESH, 2: occupancy at or above which the source wait asserts.
- MIN_GAP, 4: minimum clk_sys cycles from one dn_wr pulse to the next (1..15).
- TAIL, 8: cycles dn_go stays high after the last write drains.

Ports:
- clk_sys  in  1  system clock (42 MHz).
- reset  in  1  synchronous, active-high reset.
- loader_download  in  1  CMD loader session active.
- loader_wr  in  1  loader write strobe, one cycle per byte.
- loader_addr  in  16  loader CPU address.
- loader_data  in  8  loader byte.
- loader_wait  out  1  back-pressure to loader.
- ioctl_download  in  1  hps download active.
- ioctl_index  in  8  hps file index.
- ioctl_wr  in  1  hps write strobe.
- ioctl_addr  in  16  hps byte offset.
- ioctl_data  in  8  hps byte.
- ioctl_wait  out  1  back-pressure to hps_io.
- ram_slot  in  1  core grants a RAM write this cycle.
- dn_go  out  1  download window to core.
- dn_wr  out  1  one-cycle RAM write pulse.
- dn_addr  out  24  RAM address.
- dn_data  out  8  RAM byte.
- overflow  out  1  sticky: a write arrived while its FIFO was full.

Behaviour:
- Reset values: all FIFOs empty, FSM in IDLE, gap counter 0. Outputs dn_go, dn_wr, loader_wait, ioctl_wait, overflow = 0; dn_addr = 0; dn_data = 0. Reset mid-transfer flushes all buffered bytes.
- Push rules:
  - Loader FIFO: pushes on loader_wr, entry {8'h00, loader_addr, loader_data}.
  - Cassette FIFO: pushes on ioctl_wr && ioctl_index==1, entry {8'h01, ioctl_addr, ioctl_data}.
  - ioctl writes with any other index are ignored; the loader handles index 2 upstream.
- Full FIFO: a push is dropped, the FIFO is unchanged, and overflow sets. overflow clears only on reset.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged. A push into an empty FIFO is not issuable until the next cycle (one-cycle minimum latency).
- Wait outputs: loader_wait = loader count >= WAIT_THRESH; ioctl_wait = cassette count >= WAIT_THRESH. Both are registered from the post-update count, so they assert the cycle after the threshold push.
- FSM states:
  - IDLE: go to ISSUE when either FIFO is non-empty or loader_download or (ioctl_download && ioctl_index==1).
  - ISSUE: dn_go=1. When ram_slot=1 and a FIFO is non-empty, pop the winner, drive dn_addr/dn_data with its entry, pulse dn_wr for exactly one cycle, load the gap counter with MIN_GAP-1, go to GAP. With no data, stay in ISSUE. When both FIFOs are empty and both sessions have ended, go to TAIL.
  - GAP: count down; at 0 return to ISSUE. ram_slot is ignored in GAP.
  - TAIL: dn_go held for TAIL cycles, then IDLE. A new push or session start in TAIL returns to ISSUE immediately.
- Arbitration: round-robin between the two FIFOs; the last winner loses a tie. The pointer resets to favour the loader.
- dn_addr and dn_data hold their value between pulses.
- Throughput: at most one write per MIN_GAP cycles, and only on a cycle where ram_slot is high.
- FIFO pointers wrap modulo DEPTH; full/empty are derived from a count of width log2(DEPTH)+1.

Test Plan:
- Reset, then a single loader write addr 16'h5200 data 8'hC3 with ram_slot=1 constantly -> dn_go rises; one dn_wr pulse carrying dn_addr=24'h005200, dn_data=8'hC3 within 2 cycles; dn_go falls TAIL cycles after loader_download drops.
- ioctl index 1 burst of 8 back-to-back bytes with ram_slot=1 and the source obeying ioctl_wait -> 8 dn_wr pulses, addresses 24'h010000..24'h010007 in order, spacing exactly 4 cycles, overflow=0; ioctl_wait high while count>=2.
- Loader and cassette each push 3 bytes in the same cycles with ram_slot=1 -> dn_wr order alternates loader, cassette, loader, ...; 6 writes total, no loss.
- ram_slot held 0 for 20 cycles during a loader burst that ignores wait -> FIFO holds 4 entries, the 5th push is dropped, overflow=1; after ram_slot=1, exactly 4 writes issue.
- ioctl index 0 and index 2 writes -> no push, no dn_wr, dn_go stays 0.
- reset asserted while 3 entries are buffered and in GAP -> next cycle all outputs are 0; releasing reset produces no dn_wr.
